// File: rtl/lives_ctl.sv
// lives_ctl: registers the collision level, takes one life per hit, then runs a blinking invincibility window.
// Latency: collision sampled at edge k, hit/lives/state update at edge k+1; no backpressure, all outputs registered.
module lives_ctl #(
    parameter int LIVES_INIT   = 3,
    parameter int INV_FRAMES   = 120,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       collision,
    input  logic       frame_tick,
    input  logic       restart,
    output logic [1:0] lives,
    output logic       hit,
    output logic       invincible,
    output logic       yoshi_vis,
    output logic       game_over
);

    localparam logic [1:0] LIVES_LD = LIVES_INIT[1:0];
    localparam logic [7:0] INV_LD   = INV_FRAMES[7:0];
    localparam logic [7:0] BLINK_LD = BLINK_FRAMES[7:0];

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        INVINC    = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t     state;
    logic       col_q;
    logic [7:0] inv_cnt;
    logic [7:0] blink_cnt;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= ALIVE;
            col_q      <= 1'b0;
            lives      <= LIVES_LD;
            hit        <= 1'b0;
            invincible <= 1'b0;
            yoshi_vis  <= 1'b1;
            game_over  <= 1'b0;
            inv_cnt    <= 8'd0;
            blink_cnt  <= 8'd0;
        end else begin
            // The raw level may glitch; only the registered copy drives decisions.
            col_q <= collision;
            hit   <= 1'b0;
            if (restart) begin
                state      <= ALIVE;
                lives      <= LIVES_LD;
                invincible <= 1'b0;
                yoshi_vis  <= 1'b1;
                game_over  <= 1'b0;
                inv_cnt    <= 8'd0;
                blink_cnt  <= 8'd0;
            end else begin
                case (state)
                    ALIVE: begin
                        if (col_q && lives != 2'd0) begin
                            hit   <= 1'b1;
                            lives <= lives - 2'd1;
                            if (lives == 2'd1) begin
                                state     <= GAME_OVER;
                                game_over <= 1'b1;
                                yoshi_vis <= 1'b1;
                            end else begin
                                state      <= INVINC;
                                invincible <= 1'b1;
                                inv_cnt    <= INV_LD;
                                blink_cnt  <= BLINK_LD;
                            end
                        end
                    end
                    INVINC: begin
                        if (frame_tick) begin
                            if (inv_cnt == 8'd1) begin
                                state      <= ALIVE;
                                invincible <= 1'b0;
                                yoshi_vis  <= 1'b1;
                                inv_cnt    <= 8'd0;
                                blink_cnt  <= 8'd0;
                            end else begin
                                inv_cnt <= inv_cnt - 8'd1;
                                if (blink_cnt == 8'd1) begin
                                    blink_cnt <= BLINK_LD;
                                    yoshi_vis <= ~yoshi_vis;
                                end else begin
                                    blink_cnt <= blink_cnt - 8'd1;
                                end
                            end
                        end
                    end
                    GAME_OVER: begin
                        game_over <= 1'b1;
                        yoshi_vis <= 1'b1;
                    end
                    default: begin
                        state <= ALIVE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lives_ctl.sv
// Bench for lives_ctl: randomized and directed stimulus against a frame-count reference model, scoreboard-checked per cycle.
module tb_lives_ctl;

    localparam int LI = 3;
    localparam int IF = 4;
    localparam int BF = 2;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       collision = 1'b0;
    logic       frame_tick = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] lives;
    logic       hit, invincible, yoshi_vis, game_over;

    lives_ctl #(.LIVES_INIT(LI), .INV_FRAMES(IF), .BLINK_FRAMES(BF)) dut (
        .pclk(pclk), .rst(rst), .collision(collision), .frame_tick(frame_tick),
        .restart(restart), .lives(lives), .hit(hit), .invincible(invincible),
        .yoshi_vis(yoshi_vis), .game_over(game_over)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [1:0] lives;
        logic       hit;
        logic       inv;
        logic       vis;
        logic       go;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   hits_seen = 0;

    // Reference model: frames elapsed inside the window instead of down-counters.
    int m_lives = LI;
    bit m_colq  = 0;
    bit m_inv   = 0;
    bit m_go    = 0;
    bit m_hit   = 0;
    int m_ticks = 0;

    function automatic obs_t model_obs();
        obs_t o;
        o.lives = m_lives[1:0];
        o.hit   = m_hit;
        o.inv   = m_inv;
        o.go    = m_go;
        o.vis   = (m_go || !m_inv) ? 1'b1 : (((m_ticks / BF) % 2) == 0);
        return o;
    endfunction

    task automatic model_edge(input bit r, input bit rs, input bit c, input bit t);
        bit old;
        if (r) begin
            m_lives = LI; m_colq = 0; m_inv = 0; m_go = 0; m_hit = 0; m_ticks = 0;
        end else begin
            old = m_colq;
            m_colq = c;
            m_hit = 0;
            if (rs) begin
                m_lives = LI; m_inv = 0; m_go = 0; m_ticks = 0;
            end else if (m_go) begin
                // nothing moves until restart
            end else if (m_inv) begin
                if (t) begin
                    m_ticks++;
                    if (m_ticks == IF) begin
                        m_inv = 0;
                        m_ticks = 0;
                    end
                end
            end else if (old && m_lives > 0) begin
                m_hit = 1;
                m_lives--;
                if (m_lives == 0) m_go = 1;
                else begin
                    m_inv = 1;
                    m_ticks = 0;
                end
            end
        end
    endtask

    task automatic step(input bit c, input bit t, input bit rs = 0, input bit r = 0);
        @(negedge pclk);
        collision  = c;
        frame_tick = t;
        restart    = rs;
        rst        = r;
        @(posedge pclk);
        #1;
        model_edge(r, rs, c, t);
        exp_q.push_back(model_obs());
    endtask

    always @(negedge pclk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{lives: lives, hit: hit, inv: invincible, vis: yoshi_vis, go: game_over};
            if (hit) hits_seen++;
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL outputs @%0t: got lives=%0d hit=%b inv=%b vis=%b go=%b, expected lives=%0d hit=%b inv=%b vis=%b go=%b",
                         $time, a.lives, a.hit, a.inv, a.vis, a.go, e.lives, e.hit, e.inv, e.vis, e.go);
            end
        end
    end

    initial begin
        int hits_before;
        // 1: reset then idle
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0);

        // 2: single-cycle collision, then walk the blink window with ticks every 3 cycles
        step(1, 0);
        step(0, 0);
        step(0, 0);
        for (int f = 0; f < 5; f++) begin
            step(0, 0);
            step(0, 0);
            step(0, 1);
        end

        // 3: sustained contact through to game over, then keep colliding and ticking
        hits_before = hits_seen;
        for (int f = 0; f < 50; f++) begin
            repeat (4) step(1, 0);
            step(1, 1);
        end
        step(0, 0);
        @(negedge pclk);
        checks++;
        if (hits_seen - hits_before != 2) begin
            fails++;
            $display("FAIL sustained_hits: got %0d hit pulses, expected 2", hits_seen - hits_before);
        end

        // 5: restart from GAME_OVER, then restart from mid-window
        step(0, 0, 1);
        repeat (2) step(0, 0);
        step(1, 0);
        step(0, 0);
        step(0, 1);
        step(0, 0, 1);
        repeat (2) step(0, 0);

        // 6: restart while col_q is high; rst mid-window; tick coincident with a hit
        step(1, 0);
        step(0, 0, 1);
        step(0, 0);
        step(1, 0);
        step(0, 1);
        step(0, 1);
        step(0, 0, 0, 1);
        step(0, 0);
        step(1, 0);
        step(0, 1);
        step(0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 149) == 0, $urandom_range(0, 499) == 0);
        end

        repeat (2) @(negedge pclk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
